conv_sequencer: RTL and testbench

Frame-level sequencer for the 2-D convolver. It loads the 9 kernel words, streams image pixels into the 3-row circular pixel memory, and runs the bit-serial multiply-accumulate for every complete 3x3 window. It then presents each result through a ready/ack handshake. It sits between the pixel source and the memory/datapath blocks, and replaces the distributed counter clock-gating with a single synchronous controller.

---
 rtl/conv_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_conv_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// Frame sequencer for the 2-D convolver: kernel load, pixel streaming
// into a 3-row circular buffer, bit-serial MAC per 3x3 window, result handshake.
//
// Ports:
//   Phi1, Reset_b_s1                 clock, synchronous active-low reset
//   Start_s1                         begin a frame (honoured in IDLE/DONE)
//   Pixel_Valid_s1 / Input_Ready_s1  kernel word / pixel handshake
//   Kernel_en_s1, Word_Sel_s1        kernel word latch strobe and one-hot word line
//   Write_Mem_s1, Row_Ptr_s1,
//   Col_s1, Row_s1                   row-buffer write strobe and position
//   Reset_Shift_s1, Shift_Right_s1,
//   No_Shift_s1, Bit_Sel_s1          datapath control (exactly one shift control high)
//   Output_Ready_s1 / Output_Ack_s1  result handshake
//   Busy_s1, Done_s1                 frame status
module conv_sequencer #(
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16,
    parameter int MAC_CYCLES = 8
) (
    input  logic       Phi1,
    input  logic       Reset_b_s1,
    input  logic       Start_s1,
    input  logic       Pixel_Valid_s1,
    output logic       Input_Ready_s1,
    output logic       Kernel_en_s1,
    output logic [8:0] Word_Sel_s1,
    output logic       Write_Mem_s1,
    output logic [1:0] Row_Ptr_s1,
    output logic [7:0] Col_s1,
    output logic [7:0] Row_s1,
    output logic       Reset_Shift_s1,
    output logic       Shift_Right_s1,
    output logic       No_Shift_s1,
    output logic [2:0] Bit_Sel_s1,
    output logic       Output_Ready_s1,
    input  logic       Output_Ack_s1,
    output logic       Busy_s1,
    output logic       Done_s1
);

    localparam int CW = $clog2(MAC_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_K  = 3'd1;
    localparam logic [2:0] S_STREAM  = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [7:0]    COL_LAST = 8'(IMG_W - 1);
    localparam logic [7:0]    ROW_LAST = 8'(IMG_H - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAC_CYCLES);

    logic [2:0]    state_q, state_d;
    logic [3:0]    k_q, k_d;
    logic [7:0]    row_q, row_d;
    logic [7:0]    col_q, col_d;
    logic [1:0]    rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic       accept;
    logic       window;
    logic       last_pix;
    logic [7:0] col_nx;
    logic [7:0] row_nx;
    logic [1:0] rptr_nx;

    assign Input_Ready_s1 = (state_q == S_LOAD_K) || (state_q == S_STREAM);
    assign accept         = Pixel_Valid_s1 & Input_Ready_s1;
    // A pixel at row>=2, col>=2 is the bottom-right of a complete 3x3 window.
    assign window         = (row_q >= 8'd2) && (col_q >= 8'd2);
    assign last_pix       = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Raster advance; the row slot follows the image row modulo 3.
    always_comb begin
        col_nx  = col_q + 8'd1;
        row_nx  = row_q;
        rptr_nx = rptr_q;
        if (col_q == COL_LAST) begin
            col_nx  = 8'd0;
            row_nx  = row_q + 8'd1;
            rptr_nx = (rptr_q == 2'd2) ? 2'd0 : rptr_q + 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        row_d   = row_q;
        col_d   = col_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start_s1) begin
                    state_d = S_LOAD_K;
                    k_d     = 4'd0;
                    row_d   = 8'd0;
                    col_d   = 8'd0;
                    rptr_d  = 2'd0;
                end
            end
            S_LOAD_K: begin
                if (accept) begin
                    if (k_q == 4'd8) begin
                        state_d = S_STREAM;
                        k_d     = 4'd0;
                        row_d   = 8'd0;
                        col_d   = 8'd0;
                        rptr_d  = 2'd0;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            S_STREAM: begin
                if (accept) begin
                    if (window) begin
                        state_d = S_COMPUTE;
                        cnt_d   = '0;
                    end else begin
                        col_d  = col_nx;
                        row_d  = row_nx;
                        rptr_d = rptr_nx;
                    end
                end
            end
            S_COMPUTE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_OUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OUT: begin
                if (Output_Ack_s1) begin
                    if (last_pix) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_STREAM;
                        col_d   = col_nx;
                        row_d   = row_nx;
                        rptr_d  = rptr_nx;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Phi1) begin
        if (!Reset_b_s1) begin
            state_q <= S_IDLE;
            k_q     <= 4'd0;
            row_q   <= 8'd0;
            col_q   <= 8'd0;
            rptr_q  <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Kernel_en_s1    = accept && (state_q == S_LOAD_K);
    assign Word_Sel_s1     = (state_q == S_LOAD_K) ? (9'd1 << k_q) : 9'd0;
    assign Write_Mem_s1    = accept && (state_q == S_STREAM);
    assign Row_Ptr_s1      = rptr_q;
    assign Col_s1          = col_q;
    assign Row_s1          = row_q;
    // Counter 0 clears the accumulator; 1..MAC_CYCLES feed bits LSB first.
    assign Reset_Shift_s1  = (state_q == S_COMPUTE) && (cnt_q == '0);
    assign Shift_Right_s1  = (state_q == S_COMPUTE) && (cnt_q != '0);
    assign No_Shift_s1     = !(Reset_Shift_s1 || Shift_Right_s1);
    assign Bit_Sel_s1      = Shift_Right_s1 ? 3'(cnt_q - CW'(1)) : 3'd0;
    assign Output_Ready_s1 = (state_q == S_OUT);
    assign Busy_s1         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign Done_s1         = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: a 16x16 instance driven through
// several frames and a 3x3 instance for the smallest legal image.
module tb_conv_sequencer;

    logic Phi1 = 1'b0;
    always #5 Phi1 = ~Phi1;

    logic       rst_b, start, pv, ack;
    logic       ir, ke, wm, rs, sr, ns, ordy, busy, done;
    logic [8:0] ws;
    logic [1:0] rp;
    logic [7:0] col, row;
    logic [2:0] bs;

    logic       rst2_b, start2, pv2, ack2;
    logic       ir2, ke2, wm2, rs2, sr2, ns2, ordy2, busy2, done2;
    logic [8:0] ws2;
    logic [1:0] rp2;
    logic [7:0] col2, row2;
    logic [2:0] bs2;

    int checks = 0;
    int errors = 0;
    int n_wr, n_res, n_ke;

    conv_sequencer dut (
        .Phi1(Phi1), .Reset_b_s1(rst_b), .Start_s1(start),
        .Pixel_Valid_s1(pv), .Input_Ready_s1(ir), .Kernel_en_s1(ke),
        .Word_Sel_s1(ws), .Write_Mem_s1(wm), .Row_Ptr_s1(rp),
        .Col_s1(col), .Row_s1(row), .Reset_Shift_s1(rs),
        .Shift_Right_s1(sr), .No_Shift_s1(ns), .Bit_Sel_s1(bs),
        .Output_Ready_s1(ordy), .Output_Ack_s1(ack),
        .Busy_s1(busy), .Done_s1(done)
    );

    conv_sequencer #(.IMG_W(3), .IMG_H(3), .MAC_CYCLES(8)) dut3 (
        .Phi1(Phi1), .Reset_b_s1(rst2_b), .Start_s1(start2),
        .Pixel_Valid_s1(pv2), .Input_Ready_s1(ir2), .Kernel_en_s1(ke2),
        .Word_Sel_s1(ws2), .Write_Mem_s1(wm2), .Row_Ptr_s1(rp2),
        .Col_s1(col2), .Row_s1(row2), .Reset_Shift_s1(rs2),
        .Shift_Right_s1(sr2), .No_Shift_s1(ns2), .Bit_Sel_s1(bs2),
        .Output_Ready_s1(ordy2), .Output_Ack_s1(ack2),
        .Busy_s1(busy2), .Done_s1(done2)
    );

    function automatic logic [63:0] pk(
        input logic ir_, ke_, input logic [8:0] ws_, input logic wm_,
        input logic [1:0] rp_, input logic [7:0] c_, r_,
        input logic rs_, sr_, ns_, input logic [2:0] bs_,
        input logic or_, bz_, dn_);
        return {25'd0, ir_, ke_, ws_, wm_, rp_, c_, r_,
                rs_, sr_, ns_, bs_, or_, bz_, dn_};
    endfunction

    localparam logic [63:0] IDLE_V = {25'd0, 1'b0, 1'b0, 9'd0, 1'b0, 2'd0,
        8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};

    function automatic logic [63:0] v1();
        return pk(ir, ke, ws, wm, rp, col, row, rs, sr, ns, bs, ordy, busy, done);
    endfunction

    function automatic logic [63:0] v2();
        return pk(ir2, ke2, ws2, wm2, rp2, col2, row2, rs2, sr2, ns2, bs2,
                  ordy2, busy2, done2);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge Phi1);
        #1;
    endtask

    task automatic load_kernel(input bit toggle);
        int k = 0;
        int c = 0;
        n_ke = 0;
        while (k < 9) begin
            pv = toggle ? (c % 2 == 0) : 1'b1;
            #1;
            if (ke) n_ke++;
            chk("load_k", v1(), pk(1'b1, pv, 9'd1 << k, 1'b0, 2'd0, 8'd0,
                8'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0));
            if (pv) k++;
            c++;
            tick();
        end
    endtask

    task automatic stream_frame(input int hold, input int rst_res);
        int res = 0;
        int r, c;
        logic [1:0] p3;
        n_wr  = 0;
        n_res = 0;
        for (int p = 0; p < 256; p++) begin
            r  = p / 16;
            c  = p % 16;
            p3 = 2'(r % 3);
            pv = 1'b1; ack = 1'b1; start = 1'b0;
            #1;
            if (wm) n_wr++;
            chk("stream", v1(), pk(1'b1, 1'b0, 9'd0, 1'b1, p3, 8'(c), 8'(r),
                1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0));
            tick();
            if (r >= 2 && c >= 2) begin
                start = 1'b1;
                for (int j = 0; j <= 8; j++) begin
                    #1;
                    chk("compute", v1(), pk(1'b0, 1'b0, 9'd0, 1'b0, p3, 8'(c),
                        8'(r), j == 0, j != 0, 1'b0,
                        (j == 0) ? 3'd0 : 3'(j - 1), 1'b0, 1'b1, 1'b0));
                    if (res == rst_res && j == 3) begin
                        start = 1'b0;
                        rst_b = 1'b0;
                        tick();
                        rst_b = 1'b1;
                        #1;
                        chk("mid_reset", v1(), IDLE_V);
                        return;
                    end
                    tick();
                end
                start = 1'b0;
                if (res == 0 && hold > 0) begin
                    ack = 1'b0;
                    for (int h = 0; h < hold; h++) begin
                        #1;
                        if (wm) n_wr++;
                        chk("out_hold", v1(), pk(1'b0, 1'b0, 9'd0, 1'b0, p3,
                            8'(c), 8'(r), 1'b0, 1'b0, 1'b1, 3'd0, 1'b1,
                            1'b1, 1'b0));
                        tick();
                    end
                    ack = 1'b1;
                end
                #1;
                if (ordy) n_res++;
                chk("out", v1(), pk(1'b0, 1'b0, 9'd0, 1'b0, p3, 8'(c), 8'(r),
                    1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0));
                tick();
                res++;
            end
        end
    endtask

    localparam logic [63:0] DONE_V = {25'd0, 1'b0, 1'b0, 9'd0, 1'b0, 2'd0,
        8'd15, 8'd15, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1};

    initial begin
        int lat;
        int r, c;
        rst_b = 1'b0; start = 1'b0; pv = 1'b0; ack = 1'b0;
        rst2_b = 1'b0; start2 = 1'b0; pv2 = 1'b0; ack2 = 1'b0;

        repeat (3) tick();
        #1;
        chk("reset", v1(), IDLE_V);
        rst_b = 1'b1;
        pv    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            chk("idle_hold", v1(), IDLE_V);
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        load_kernel(1'b1);
        chk("ke_count", 64'(n_ke), 64'd9);
        stream_frame(0, -1);
        chk("wr_count", 64'(n_wr), 64'd256);
        chk("res_count", 64'(n_res), 64'd196);
        #1;
        chk("done", v1(), DONE_V);
        tick();
        #1;
        chk("done_hold", v1(), DONE_V);

        start = 1'b1;
        tick();
        start = 1'b0;
        load_kernel(1'b0);
        stream_frame(20, 4);
        tick();
        #1;
        chk("post_reset_idle", v1(), IDLE_V);

        start = 1'b1;
        tick();
        start = 1'b0;
        load_kernel(1'b0);
        chk("ke_count2", 64'(n_ke), 64'd9);
        stream_frame(0, -1);
        chk("wr_count2", 64'(n_wr), 64'd256);
        chk("res_count2", 64'(n_res), 64'd196);
        #1;
        chk("done2", v1(), DONE_V);

        // 3x3 image: one window, then DONE
        tick();
        #1;
        chk("r3_reset", v2(), IDLE_V);
        rst2_b = 1'b1;
        start2 = 1'b1;
        ack2   = 1'b1;
        tick();
        start2 = 1'b0;
        pv2    = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("r3_load", v2(), pk(1'b1, 1'b1, 9'd1 << i, 1'b0, 2'd0, 8'd0,
                8'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0));
            tick();
        end
        for (int p = 0; p < 9; p++) begin
            r = p / 3;
            c = p % 3;
            #1;
            chk("r3_stream", v2(), pk(1'b1, 1'b0, 9'd0, 1'b1, 2'(r), 8'(c),
                8'(r), 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0));
            tick();
        end
        lat = 1;
        #1;
        while (!ordy2 && lat < 30) begin
            tick();
            #1;
            lat++;
        end
        chk("r3_latency", 64'(lat), 64'd10);
        tick();
        #1;
        chk("r3_done", v2(), pk(1'b0, 1'b0, 9'd0, 1'b0, 2'd2, 8'd2, 8'd2,
            1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1));
        pv2    = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        #1;
        chk("r3_restart", v2(), pk(1'b1, 1'b0, 9'd1, 1'b0, 2'd0, 8'd0, 8'd0,
            1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
